// File: rtl/dtcore32_pkg.sv
// dtcore32_pkg: shared size encodings, bridge FSM states and load alignment helpers.
package dtcore32_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00) || size == SZ_ILL;
  endfunction

  // Lane select by byte offset, then sign- or zero-extend narrow loads.
  function automatic logic [31:0] load_extract(input logic [31:0] raw, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = raw[{off, 3'b000} +: 8];
    h = off[1] ? raw[31:16] : raw[15:0];
    return size == SZ_BYTE ? {{24{~uns & b[7]}}, b} :
           size == SZ_HALF ? {{16{~uns & h[15]}}, h} : raw;
  endfunction
endpackage

// File: rtl/dtcore32_dmem_lane.sv
// dtcore32_dmem_lane: combinational byte-enable, store replication and load alignment.
module dtcore32_dmem_lane
  import dtcore32_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata
);
  always_comb begin
    be         = size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? 4'b0011 << off : 4'b1111;
    wdata_lane = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    rdata      = load_extract(raw, off, size, uns);
  end
endmodule

// File: rtl/dtcore32_dmem_bridge.sv
// dtcore32_dmem_bridge: MEM-stage load/store to valid/ready bus bridge with timeout and flush discard.
module dtcore32_dmem_bridge
  import dtcore32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MEM_dmem_rd_en_i,
  input  logic        MEM_dmem_wr_en_i,
  input  logic [31:0] MEM_dmem_addr_i,
  input  logic [31:0] MEM_dmem_wdata_i,
  input  logic [1:0]  MEM_dmem_size_i,
  input  logic        MEM_dmem_unsigned_i,
  input  logic        MEM_flush_i,
  output logic [31:0] MEM_dmem_rdata_o,
  output logic        MEM_dmem_stall_o,
  output logic        MEM_dmem_misaligned_o,
  output logic        MEM_dmem_fault_o,
  output logic        bus_req_valid_o,
  input  logic        bus_req_ready_i,
  output logic        bus_req_we_o,
  output logic [31:0] bus_req_addr_o,
  output logic [31:0] bus_req_wdata_o,
  output logic [3:0]  bus_req_be_o,
  input  logic        bus_rsp_valid_i,
  input  logic [31:0] bus_rsp_rdata_i,
  input  logic        bus_rsp_err_i
);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic [15:0] cnt_q;
  logic        uns_q, we_q, err_q, discard_q;
  logic        req, misal, accept, timeout, in_req, busy, done;
  logic [3:0]  be;
  logic [31:0] lane_wdata, lane_rdata;

  assign req     = MEM_dmem_rd_en_i | MEM_dmem_wr_en_i;
  assign misal   = is_misaligned(MEM_dmem_size_i, MEM_dmem_addr_i[1:0]);
  // rst_i gates the IDLE combinational outputs so nothing leaks while in reset.
  assign accept  = ~rst_i & state_q == IDLE & req & ~misal & ~MEM_flush_i;
  assign timeout = cnt_q == CNT_LAST;
  assign in_req  = state_q == REQ;
  assign busy    = in_req | state_q == RSP;
  assign done    = state_q == DONE;

  dtcore32_dmem_lane u_lane (
    .off        (addr_q[1:0]),
    .size       (size_q),
    .uns        (uns_q),
    .wdata      (wdata_q),
    .raw        (rdata_q),
    .be         (be),
    .wdata_lane (lane_wdata),
    .rdata      (lane_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? REQ : IDLE;
      REQ:     state_d = bus_req_ready_i ? RSP : REQ;
      RSP:     state_d = (bus_rsp_valid_i | timeout) ? DONE : RSP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    MEM_dmem_stall_o      = busy | accept;
    MEM_dmem_misaligned_o = ~rst_i & state_q == IDLE & req & misal & ~MEM_flush_i;
    MEM_dmem_rdata_o      = (done & ~discard_q & ~we_q) ? lane_rdata : 32'h0;
    MEM_dmem_fault_o      = done & ~discard_q & err_q;
    bus_req_valid_o       = in_req;
    bus_req_we_o          = in_req & we_q;
    bus_req_addr_o        = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    bus_req_wdata_o       = in_req ? lane_wdata : 32'h0;
    bus_req_be_o          = in_req ? be : 4'h0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      discard_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        addr_q    <= MEM_dmem_addr_i;
        wdata_q   <= MEM_dmem_wdata_i;
        size_q    <= MEM_dmem_size_i;
        uns_q     <= MEM_dmem_unsigned_i;
        we_q      <= MEM_dmem_wr_en_i;
        rdata_q   <= '0;
        err_q     <= 1'b0;
        discard_q <= 1'b0;
      end
      cnt_q <= state_q == RSP ? cnt_q + 16'd1 : 16'd0;
      if (state_q == RSP && bus_rsp_valid_i) begin
        rdata_q <= bus_rsp_rdata_i;
        err_q   <= bus_rsp_err_i;
      end else if (state_q == RSP && timeout) begin
        err_q   <= 1'b1;
      end
      // A flushed transaction still runs to completion on the bus; only its result is dropped.
      if (busy && MEM_flush_i) discard_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dtcore32_dmem_bridge.sv
// tb_dtcore32_dmem_bridge: directed checks of the data-memory bus bridge.
module tb_dtcore32_dmem_bridge;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MEM_dmem_rd_en_i, MEM_dmem_wr_en_i, MEM_dmem_unsigned_i, MEM_flush_i;
  logic [31:0] MEM_dmem_addr_i, MEM_dmem_wdata_i;
  logic [1:0]  MEM_dmem_size_i;
  logic [31:0] MEM_dmem_rdata_o;
  logic        MEM_dmem_stall_o, MEM_dmem_misaligned_o, MEM_dmem_fault_o;
  logic        bus_req_valid_o, bus_req_ready_i, bus_req_we_o;
  logic [31:0] bus_req_addr_o, bus_req_wdata_o;
  logic [3:0]  bus_req_be_o;
  logic        bus_rsp_valid_i, bus_rsp_err_i;
  logic [31:0] bus_rsp_rdata_i;

  int checks = 0;
  int errors = 0;
  int stalls;
  int n;

  dtcore32_dmem_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MEM_dmem_rd_en_i(MEM_dmem_rd_en_i), .MEM_dmem_wr_en_i(MEM_dmem_wr_en_i),
    .MEM_dmem_addr_i(MEM_dmem_addr_i), .MEM_dmem_wdata_i(MEM_dmem_wdata_i),
    .MEM_dmem_size_i(MEM_dmem_size_i), .MEM_dmem_unsigned_i(MEM_dmem_unsigned_i),
    .MEM_flush_i(MEM_flush_i), .MEM_dmem_rdata_o(MEM_dmem_rdata_o),
    .MEM_dmem_stall_o(MEM_dmem_stall_o), .MEM_dmem_misaligned_o(MEM_dmem_misaligned_o),
    .MEM_dmem_fault_o(MEM_dmem_fault_o), .bus_req_valid_o(bus_req_valid_o),
    .bus_req_ready_i(bus_req_ready_i), .bus_req_we_o(bus_req_we_o),
    .bus_req_addr_o(bus_req_addr_o), .bus_req_wdata_o(bus_req_wdata_o),
    .bus_req_be_o(bus_req_be_o), .bus_rsp_valid_i(bus_rsp_valid_i),
    .bus_rsp_rdata_i(bus_rsp_rdata_i), .bus_rsp_err_i(bus_rsp_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  // Full load with ready and response available immediately: REQ and RSP each take one cycle.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz, input logic u,
                         input logic [31:0] d, input logic e, input logic [31:0] exp_r, input logic exp_f);
    int k;
    MEM_dmem_rd_en_i = 1'b1; MEM_dmem_addr_i = a; MEM_dmem_size_i = sz; MEM_dmem_unsigned_i = u;
    bus_req_ready_i = 1'b1; bus_rsp_valid_i = 1'b1; bus_rsp_rdata_i = d; bus_rsp_err_i = e;
    step;
    MEM_dmem_rd_en_i = 1'b0;
    #1;
    k = 0;
    while (MEM_dmem_stall_o && k < 20) begin
      step;
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'd2);
    chk({tag, "_rdata"}, MEM_dmem_rdata_o, exp_r);
    chk({tag, "_fault"}, 32'(MEM_dmem_fault_o), 32'(exp_f));
    bus_req_ready_i = 1'b0; bus_rsp_valid_i = 1'b0; bus_rsp_err_i = 1'b0;
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    MEM_dmem_rd_en_i = 1'b1; MEM_dmem_wr_en_i = 1'b0; MEM_dmem_addr_i = 32'h1000;
    MEM_dmem_wdata_i = '0; MEM_dmem_size_i = 2'b10; MEM_dmem_unsigned_i = 1'b0; MEM_flush_i = 1'b0;
    bus_req_ready_i = 1'b1; bus_rsp_valid_i = 1'b0; bus_rsp_rdata_i = '0; bus_rsp_err_i = 1'b0;
    #3;
    chk("rst_stall", 32'(MEM_dmem_stall_o), 0);
    chk("rst_valid", 32'(bus_req_valid_o), 0);
    chk("rst_rdata", MEM_dmem_rdata_o, 0);
    step;
    step;
    chk("rst_valid2", 32'(bus_req_valid_o), 0);
    MEM_dmem_rd_en_i = 1'b0;
    rst_i = 1'b0;
    step;

    // Signed byte load at offset 3
    MEM_dmem_rd_en_i = 1'b1; MEM_dmem_addr_i = 32'h1003; MEM_dmem_size_i = 2'b00;
    bus_req_ready_i = 1'b1; bus_rsp_valid_i = 1'b1; bus_rsp_rdata_i = 32'h80FF_FF12;
    #1;
    chk("lb_idle_stall", 32'(MEM_dmem_stall_o), 1);
    chk("lb_idle_valid", 32'(bus_req_valid_o), 0);
    stalls = int'(MEM_dmem_stall_o);
    step;
    MEM_dmem_rd_en_i = 1'b0;
    #1;
    chk("lb_req_valid", 32'(bus_req_valid_o), 1);
    chk("lb_req_addr", bus_req_addr_o, 32'h1000);
    chk("lb_req_we", 32'(bus_req_we_o), 0);
    stalls += int'(MEM_dmem_stall_o);
    step;
    chk("lb_rsp_valid", 32'(bus_req_valid_o), 0);
    stalls += int'(MEM_dmem_stall_o);
    step;
    chk("lb_done_rdata", MEM_dmem_rdata_o, 32'hFFFF_FF80);
    chk("lb_done_fault", 32'(MEM_dmem_fault_o), 0);
    chk("lb_done_stall", 32'(MEM_dmem_stall_o), 0);
    chk("lb_stall_cycles", 32'(stalls), 3);
    step;
    chk("lb_idle_rdata", MEM_dmem_rdata_o, 0);
    bus_req_ready_i = 1'b0; bus_rsp_valid_i = 1'b0;

    // Half store with ready held off for four REQ cycles
    MEM_dmem_wr_en_i = 1'b1; MEM_dmem_addr_i = 32'h2002; MEM_dmem_size_i = 2'b01;
    MEM_dmem_wdata_i = 32'h0000_BEEF;
    #1;
    chk("sh_idle_stall", 32'(MEM_dmem_stall_o), 1);
    step;
    MEM_dmem_wr_en_i = 1'b0; MEM_dmem_wdata_i = 32'h1111_2222; MEM_dmem_addr_i = 32'h0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("sh_valid", 32'(bus_req_valid_o), 1);
      chk("sh_we", 32'(bus_req_we_o), 1);
      chk("sh_be", 32'(bus_req_be_o), 32'hC);
      chk("sh_wdata", bus_req_wdata_o, 32'hBEEF_BEEF);
      chk("sh_addr", bus_req_addr_o, 32'h2000);
      chk("sh_stall", 32'(MEM_dmem_stall_o), 1);
      step;
    end
    bus_req_ready_i = 1'b1;
    #1;
    chk("sh_hs_valid", 32'(bus_req_valid_o), 1);
    step;
    bus_req_ready_i = 1'b0; bus_rsp_valid_i = 1'b1; bus_rsp_rdata_i = 32'h1234_5678;
    #1;
    chk("sh_rsp_valid", 32'(bus_req_valid_o), 0);
    step;
    bus_rsp_valid_i = 1'b0;
    chk("sh_done_rdata", MEM_dmem_rdata_o, 0);
    chk("sh_done_fault", 32'(MEM_dmem_fault_o), 0);
    step;

    // Misaligned and illegal sizes never reach the bus
    MEM_dmem_rd_en_i = 1'b1; MEM_dmem_addr_i = 32'h3001; MEM_dmem_size_i = 2'b10;
    bus_req_ready_i = 1'b1;
    #1;
    chk("mis_word_flag", 32'(MEM_dmem_misaligned_o), 1);
    chk("mis_word_stall", 32'(MEM_dmem_stall_o), 0);
    step;
    chk("mis_word_valid", 32'(bus_req_valid_o), 0);
    chk("mis_word_flag2", 32'(MEM_dmem_misaligned_o), 1);
    MEM_dmem_size_i = 2'b01;
    #1;
    chk("mis_half_flag", 32'(MEM_dmem_misaligned_o), 1);
    MEM_dmem_addr_i = 32'h3000; MEM_dmem_size_i = 2'b11;
    #1;
    chk("mis_ill_flag", 32'(MEM_dmem_misaligned_o), 1);
    MEM_dmem_size_i = 2'b01; MEM_dmem_addr_i = 32'h3002;
    #1;
    chk("half_ok_flag", 32'(MEM_dmem_misaligned_o), 0);
    MEM_flush_i = 1'b1;
    #1;
    chk("flush_idle_stall", 32'(MEM_dmem_stall_o), 0);
    MEM_dmem_addr_i = 32'h3001;
    #1;
    chk("flush_idle_mis", 32'(MEM_dmem_misaligned_o), 0);
    step;
    chk("flush_idle_valid", 32'(bus_req_valid_o), 0);
    MEM_flush_i = 1'b0; MEM_dmem_rd_en_i = 1'b0; bus_req_ready_i = 1'b0;
    step;

    // Timeout after eight RSP cycles, late response ignored
    MEM_dmem_rd_en_i = 1'b1; MEM_dmem_addr_i = 32'h4000; MEM_dmem_size_i = 2'b10;
    bus_req_ready_i = 1'b1;
    step;
    MEM_dmem_rd_en_i = 1'b0;
    step;
    n = 0;
    while (MEM_dmem_stall_o && n < 30) begin
      n++;
      step;
    end
    chk("to_rsp_cycles", 32'(n), 8);
    chk("to_fault", 32'(MEM_dmem_fault_o), 1);
    chk("to_rdata", MEM_dmem_rdata_o, 0);
    chk("to_done_valid", 32'(bus_req_valid_o), 0);
    bus_rsp_valid_i = 1'b1; bus_rsp_rdata_i = 32'h5555_5555; bus_rsp_err_i = 1'b1;
    step;
    chk("late_fault", 32'(MEM_dmem_fault_o), 0);
    chk("late_stall", 32'(MEM_dmem_stall_o), 0);
    chk("late_rdata", MEM_dmem_rdata_o, 0);
    step;
    chk("late_valid", 32'(bus_req_valid_o), 0);
    bus_rsp_valid_i = 1'b0; bus_rsp_err_i = 1'b0; bus_req_ready_i = 1'b0;

    // Flush in RSP with an error response
    MEM_dmem_rd_en_i = 1'b1; MEM_dmem_addr_i = 32'h5000;
    bus_req_ready_i = 1'b1;
    step;
    MEM_dmem_rd_en_i = 1'b0;
    step;
    MEM_flush_i = 1'b1; bus_rsp_valid_i = 1'b1; bus_rsp_err_i = 1'b1; bus_rsp_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("fl_rsp_stall", 32'(MEM_dmem_stall_o), 1);
    step;
    chk("fl_done_fault", 32'(MEM_dmem_fault_o), 0);
    chk("fl_done_rdata", MEM_dmem_rdata_o, 0);
    chk("fl_done_stall", 32'(MEM_dmem_stall_o), 0);
    MEM_flush_i = 1'b0; bus_rsp_valid_i = 1'b0; bus_rsp_err_i = 1'b0; bus_req_ready_i = 1'b0;
    step;

    // Extension variants and an unflushed bus error
    do_load("lhu", 32'h6002, 2'b01, 1'b1, 32'h8001_7FFF, 1'b0, 32'h0000_8001, 1'b0);
    do_load("lh_err", 32'h6002, 2'b01, 1'b0, 32'h8001_7FFF, 1'b1, 32'hFFFF_8001, 1'b1);
    do_load("lbu", 32'h7001, 2'b00, 1'b1, 32'h0000_AB00, 1'b0, 32'h0000_00AB, 1'b0);
    do_load("lw", 32'h7004, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0);

    // Asynchronous reset in REQ and in RSP
    MEM_dmem_wr_en_i = 1'b1; MEM_dmem_addr_i = 32'h9000; MEM_dmem_size_i = 2'b10;
    step;
    MEM_dmem_wr_en_i = 1'b0;
    #1;
    chk("rq_pre_valid", 32'(bus_req_valid_o), 1);
    rst_i = 1'b1;
    #1;
    chk("rq_rst_valid", 32'(bus_req_valid_o), 0);
    chk("rq_rst_be", 32'(bus_req_be_o), 0);
    step;
    rst_i = 1'b0;
    MEM_dmem_rd_en_i = 1'b1; MEM_dmem_addr_i = 32'h8000; bus_req_ready_i = 1'b1;
    step;
    MEM_dmem_rd_en_i = 1'b0;
    step;
    chk("rs_pre_stall", 32'(MEM_dmem_stall_o), 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rs_rst_stall", 32'(MEM_dmem_stall_o), 0);
    chk("rs_rst_valid", 32'(bus_req_valid_o), 0);
    step;
    bus_rsp_valid_i = 1'b1; bus_rsp_rdata_i = 32'h7777_7777;
    step;
    chk("rs_rst_rdata", MEM_dmem_rdata_o, 0);
    bus_rsp_valid_i = 1'b0; bus_req_ready_i = 1'b0;
    rst_i = 1'b0;
    step;
    chk("rs_after_fault", 32'(MEM_dmem_fault_o), 0);
    do_load("post_rst", 32'h8004, 2'b10, 1'b0, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
